// File: rtl/alu_driver.sv
// -----------------------------------------------------------------------------
// alu_driver
//
// Command-side initiator for the alu block. It takes one operation at a time
// from the upstream sequencer, drives the ALU operands, control code and enable,
// and waits for the ALU's valid. That wait is bounded by a timeout. The driver
// then returns the result, or an error flag, to the downstream consumer. It also
// counts completed result handshakes.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where valid
// and ready are both high. A producer holds valid and its payload stable until
// that edge. Ready never depends combinationally on valid.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_a, cmd_b, cmd_op are the payload
//   alu_a, alu_b         registered operands to the ALU
//   alu_ctrl, alu_en     registered control code and enable to the ALU
//   alu_out, alu_valid   result and valid from the ALU
//   res_valid/res_ready  result handshake; res_data, res_op, res_err are the payload
//   op_count             completed result handshakes, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module alu_driver #(
    parameter int DATA_W  = 4,
    parameter int OUT_W   = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [1:0]        cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_ctrl,
    output logic              alu_en,
    input  logic [OUT_W-1:0]  alu_out,
    input  logic              alu_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic [1:0]        res_op,
    output logic              res_err,
    output logic [CNT_W-1:0]  op_count
);

    // The timer only needs to reach TIMEOUT-1.
    localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;

    // The only combinational output: it depends on the state register alone.
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            alu_en    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready is implied by being in IDLE.
                    if (cmd_valid) begin
                        alu_a    <= cmd_a;
                        alu_b    <= cmd_b;
                        alu_ctrl <= cmd_op;
                        res_op   <= cmd_op;
                        alu_en   <= 1'b1;
                        timer    <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // The ALU's valid is ignored while timer == 0. A valid seen
                    // then may be left over from the previous operands, because
                    // the ALU has not yet had an enabled edge with the new ones.
                    if ((timer != '0) && alu_valid) begin
                        res_data  <= alu_out;
                        res_err   <= 1'b0;
                        alu_en    <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else if (timer == T_LAST) begin
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        alu_en    <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    // Timeouts count as completed operations too.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
module tb_alu_driver;

  localparam int DATA_W  = 4;
  localparam int OUT_W   = 8;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 2;   // small counter so the wrap is reachable

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a = '0;
  logic [DATA_W-1:0] cmd_b = '0;
  logic [1:0]        cmd_op = '0;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_ctrl;
  logic              alu_en;
  logic [OUT_W-1:0]  alu_out = '0;
  logic              alu_valid = 1'b0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [OUT_W-1:0]  res_data;
  logic [1:0]        res_op;
  logic              res_err;
  logic [CNT_W-1:0]  op_count;

  alu_driver #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_op   (cmd_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_en   (alu_en),
    .alu_out  (alu_out),
    .alu_valid(alu_valid),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_op   (res_op),
    .res_err  (res_err),
    .op_count (op_count)
  );

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;   // completed handshakes since the last reset

  // ---------------- ALU model ----------------
  // mode 0: valid after alu_lat enabled edges; out = ref_alu(operands)
  // mode 1: never valid
  // mode 2: valid tied high; out = AA, then 55 from one cycle after en rises
  int   alu_mode = 0;
  int   alu_lat  = 2;
  int   alu_cnt  = 0;
  logic en_b;

  function automatic logic [OUT_W-1:0] ref_alu(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [1:0] op);
    logic [OUT_W-1:0] xa;
    logic [OUT_W-1:0] xb;
    xa = OUT_W'(a);
    xb = OUT_W'(b);
    case (op)
      2'd0:    return xa + xb;
      2'd1:    return xa - xb;
      2'd2:    return xa & xb;
      default: return xa ^ xb;
    endcase
  endfunction

  always @(posedge clk) begin
    en_b = alu_en;          // value of enable seen by the ALU at this edge
    #1;
    if (!en_b) alu_cnt = 0;
    else       alu_cnt = alu_cnt + 1;
    case (alu_mode)
      0: begin
        alu_valid = (alu_cnt > 0) && (alu_cnt >= alu_lat);
        alu_out   = alu_valid ? ref_alu(alu_a, alu_b, alu_ctrl) : 8'h00;
      end
      1: begin
        alu_valid = 1'b0;
        alu_out   = 8'h00;
      end
      default: begin
        alu_valid = 1'b1;
        alu_out   = (alu_cnt >= 1) ? 8'h55 : 8'hAA;
      end
    endcase
  end

  // Reference: edges after the accept edge until res_valid, and whether it times out.
  function automatic int exp_edges(input int lat);
    int k;
    k = (lat + 1 < 2) ? 2 : lat + 1;
    return (k > TIMEOUT) ? TIMEOUT : k;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Presents a command and returns just after its accept edge.
  task automatic issue(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [1:0] op);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
    end
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Counts edges until res_valid; en_cyc counts post-edge samples with alu_en high.
  task automatic wait_res(output int k, output int en_cyc);
    k      = 0;
    en_cyc = (alu_en === 1'b1) ? 1 : 0;
    while (res_valid !== 1'b1 && k < 40) begin
      tick();
      k++;
      if (res_valid !== 1'b1 && alu_en === 1'b1) en_cyc++;
    end
    if (res_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_res: res_valid=%b required 1 within 40 cycles", res_valid);
    end
  endtask

  task automatic handshake;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
    end
    checks++;
    if ({alu_a, alu_b, alu_ctrl, alu_en} !== '0) begin
      errors++; $display("FAIL reset_alu_side: got a=%h b=%h ctrl=%h en=%b required all 0",
                         alu_a, alu_b, alu_ctrl, alu_en);
    end
    checks++;
    if ({res_valid, res_data, res_op, res_err, op_count} !== '0) begin
      errors++; $display("FAIL reset_res_side: got v=%b d=%h op=%h err=%b cnt=%0d required all 0",
                         res_valid, res_data, res_op, res_err, op_count);
    end
    rst = 1'b0;
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_add;
    int k, en_cyc;
    alu_mode = 0; alu_lat = 2;
    issue(4'b1110, 4'b0111, 2'b00);
    checks++;
    if (alu_en !== 1'b1 || alu_a !== 4'b1110 || alu_b !== 4'b0111 || alu_ctrl !== 2'b00) begin
      errors++; $display("FAIL add_drive: got en=%b a=%h b=%h ctrl=%h required 1 e 7 0",
                         alu_en, alu_a, alu_b, alu_ctrl);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL add_cmd_ready_busy: got %b required 0", cmd_ready);
    end
    wait_res(k, en_cyc);
    checks++;
    if (k != 3) begin
      errors++; $display("FAIL add_latency: got %0d required 3", k);
    end
    checks++;
    if (res_data !== 8'h15 || res_op !== 2'b00 || res_err !== 1'b0 || alu_en !== 1'b0) begin
      errors++; $display("FAIL add_result: got d=%h op=%h err=%b en=%b required 15 0 0 0",
                         res_data, res_op, res_err, alu_en);
    end
    handshake();
    checks++;
    if (op_count !== CNT_W'(exp_cnt) || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL add_handshake: got cnt=%0d v=%b rdy=%b required %0d 0 1",
                         op_count, res_valid, cmd_ready, exp_cnt % 4);
    end
  endtask

  task automatic test_timeout;
    int k, en_cyc;
    alu_mode = 1;
    issue(4'h3, 4'h4, 2'b10);
    wait_res(k, en_cyc);
    checks++;
    if (en_cyc != TIMEOUT || k != TIMEOUT) begin
      errors++; $display("FAIL timeout_en_cycles: got en=%0d edges=%0d required %0d",
                         en_cyc, k, TIMEOUT);
    end
    checks++;
    if (res_err !== 1'b1 || res_data !== 8'h00 || res_op !== 2'b10 || alu_en !== 1'b0) begin
      errors++; $display("FAIL timeout_result: got err=%b d=%h op=%h en=%b required 1 00 2 0",
                         res_err, res_data, res_op, alu_en);
    end
    handshake();
    checks++;
    if (op_count !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL timeout_count: got %0d required %0d", op_count, exp_cnt % 4);
    end
  endtask

  task automatic test_backpressure;
    int k, en_cyc;
    logic [OUT_W-1:0] d0;
    alu_mode = 0; alu_lat = 1;
    issue(4'h5, 4'h6, 2'b01);
    wait_res(k, en_cyc);
    d0 = ref_alu(4'h5, 4'h6, 2'b01);
    checks++;
    if (k != 2 || res_data !== d0) begin
      errors++; $display("FAIL bp_first: got edges=%0d d=%h required 2 %h", k, res_data, d0);
    end
    cmd_a = 4'h9; cmd_b = 4'h2; cmd_op = 2'b11; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_data !== d0 || res_op !== 2'b01 || res_err !== 1'b0 ||
          cmd_ready !== 1'b0 || alu_a !== 4'h5) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h op=%h err=%b rdy=%b a=%h required 1 %h 1 0 0 5",
                           i, res_valid, res_data, res_op, res_err, cmd_ready, alu_a, d0);
      end
    end
    handshake();
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 4'h5 || alu_en !== 1'b0 ||
        op_count !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL bp_release: got v=%b rdy=%b a=%h en=%b cnt=%0d required 0 1 5 0 %0d",
                         res_valid, cmd_ready, alu_a, alu_en, op_count, exp_cnt % 4);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (alu_a !== 4'h9 || alu_b !== 4'h2 || alu_ctrl !== 2'b11 || alu_en !== 1'b1) begin
      errors++; $display("FAIL bp_second_accept: got a=%h b=%h ctrl=%h en=%b required 9 2 3 1",
                         alu_a, alu_b, alu_ctrl, alu_en);
    end
    wait_res(k, en_cyc);
    checks++;
    if (res_data !== 8'h0B || res_op !== 2'b11) begin
      errors++; $display("FAIL bp_second_result: got d=%h op=%h required 0b 3", res_data, res_op);
    end
    handshake();
  endtask

  task automatic test_stale;
    int k, en_cyc;
    alu_mode = 2;
    issue(4'h1, 4'h2, 2'b00);
    wait_res(k, en_cyc);
    checks++;
    if (k != 2 || res_data !== 8'h55 || res_err !== 1'b0) begin
      errors++; $display("FAIL stale_valid: got edges=%0d d=%h err=%b required 2 55 0",
                         k, res_data, res_err);
    end
    handshake();
    alu_mode = 0;
  endtask

  task automatic test_reset_mid_wait;
    int k, en_cyc;
    alu_mode = 1;
    issue(4'hA, 4'hB, 2'b10);
    repeat (3) tick();      // timer now 3
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || {alu_a, alu_b, alu_ctrl, alu_en} !== '0 ||
        {res_valid, res_data, res_op, res_err, op_count} !== '0) begin
      errors++; $display("FAIL rst_mid_wait: got rdy=%b a=%h b=%h ctrl=%h en=%b v=%b d=%h op=%h err=%b cnt=%0d required rdy=1 rest 0",
                         cmd_ready, alu_a, alu_b, alu_ctrl, alu_en, res_valid, res_data, res_op, res_err, op_count);
    end
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    alu_mode = 0; alu_lat = 2;
    issue(4'b1100, 4'b0110, 2'b01);
    wait_res(k, en_cyc);
    checks++;
    if (k != 3 || res_data !== 8'h06 || res_op !== 2'b01 || res_err !== 1'b0) begin
      errors++; $display("FAIL rst_recover: got edges=%0d d=%h op=%h err=%b required 3 06 1 0",
                         k, res_data, res_op, res_err);
    end
    handshake();
    checks++;
    if (op_count !== CNT_W'(1)) begin
      errors++; $display("FAIL rst_recover_count: got %0d required 1", op_count);
    end
  endtask

  task automatic test_counter_wrap;
    int k, en_cyc;
    int exp_tab[5];
    exp_tab = '{1, 2, 3, 0, 1};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    alu_mode = 0; alu_lat = 1;
    for (int i = 0; i < 5; i++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      wait_res(k, en_cyc);
      handshake();
      checks++;
      if (op_count !== CNT_W'(exp_tab[i])) begin
        errors++; $display("FAIL wrap_count[%0d]: got %0d required %0d", i, op_count, exp_tab[i]);
      end
    end
  endtask

  // Latency boundaries first (14 still succeeds, 15 times out), then random ops.
  task automatic test_random;
    int k, en_cyc, lat, dly, ek;
    int lat_tab[4];
    logic [DATA_W-1:0] a, b;
    logic [1:0] op;
    logic [OUT_W-1:0] ed;
    logic ee;
    lat_tab = '{1, 2, 14, 15};
    alu_mode = 0;
    for (int i = 0; i < 16; i++) begin
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      op  = 2'($urandom_range(0, 3));
      lat = (i < 4) ? lat_tab[i] : $urandom_range(1, 17);
      dly = $urandom_range(0, 3);
      alu_lat = lat;
      ek = exp_edges(lat);
      ee = (lat + 1 > TIMEOUT);
      ed = ee ? 8'h00 : ref_alu(a, b, op);
      issue(a, b, op);
      wait_res(k, en_cyc);
      checks++;
      if (k != ek || res_data !== ed || res_op !== op || res_err !== ee) begin
        errors++; $display("FAIL rand[%0d] lat=%0d: got edges=%0d d=%h op=%h err=%b required %0d %h %h %b",
                           i, lat, k, res_data, res_op, res_err, ek, ed, op, ee);
      end
      repeat (dly) tick();
      checks++;
      if (res_valid !== 1'b1 || res_data !== ed) begin
        errors++; $display("FAIL rand_hold[%0d]: got v=%b d=%h required 1 %h", i, res_valid, res_data, ed);
      end
      handshake();
      checks++;
      if (op_count !== CNT_W'(exp_cnt)) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d required %0d", i, op_count, exp_cnt % 4);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add();
    test_timeout();
    test_backpressure();
    test_stale();
    test_reset_mid_wait();
    test_counter_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
